// File: rtl/seven_seg.sv
// Registered hex-to-seven-segment decoder with one-hot anode select for an 8-digit display.
// Latency: 1 clk. Inputs are sampled on every rising edge, and outputs change only at clock edges.
// Backpressure: none. There is no handshake, so every cycle's inputs are decoded.
module seven_seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic [2:0] sel,
    output logic [6:0] segment,
    output logic [7:0] anode
);

    // The decode tables are written for active-low drive. An active-high board
    // flips every bit, including the blank value, so reset goes through the same mask.
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [7:0] AN_INV  = AN_ACTIVE_LOW  ? 8'h00 : 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_BLANK  = 8'hFF;

    logic [6:0] seg_al;
    logic [7:0] an_al;

    // Hex glyph lookup, bit order {g,f,e,d,c,b,a}. An unknown input falls to blank.
    always_comb begin
        seg_al = SEG_BLANK;
        case (num)
            4'h0:    seg_al = 7'b1000000;
            4'h1:    seg_al = 7'b1111001;
            4'h2:    seg_al = 7'b0100100;
            4'h3:    seg_al = 7'b0110000;
            4'h4:    seg_al = 7'b0011001;
            4'h5:    seg_al = 7'b0010010;
            4'h6:    seg_al = 7'b0000010;
            4'h7:    seg_al = 7'b1111000;
            4'h8:    seg_al = 7'b0000000;
            4'h9:    seg_al = 7'b0010000;
            4'hA:    seg_al = 7'b0001000;
            4'hB:    seg_al = 7'b0000011;
            4'hC:    seg_al = 7'b1000110;
            4'hD:    seg_al = 7'b0100001;
            4'hE:    seg_al = 7'b0000110;
            4'hF:    seg_al = 7'b0001110;
            default: seg_al = SEG_BLANK;
        endcase
    end

    // One-hot-low anode select. An unknown select leaves every digit dark.
    always_comb begin
        an_al = AN_BLANK;
        case (sel)
            3'd0:    an_al = 8'b1111_1110;
            3'd1:    an_al = 8'b1111_1101;
            3'd2:    an_al = 8'b1111_1011;
            3'd3:    an_al = 8'b1111_0111;
            3'd4:    an_al = 8'b1110_1111;
            3'd5:    an_al = 8'b1101_1111;
            3'd6:    an_al = 8'b1011_1111;
            3'd7:    an_al = 8'b0111_1111;
            default: an_al = AN_BLANK;
        endcase
    end

    // Output registers. Reset blanks the display and takes priority over the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            segment <= SEG_BLANK ^ SEG_INV;
            anode   <= AN_BLANK ^ AN_INV;
        end else begin
            segment <= seg_al ^ SEG_INV;
            anode   <= an_al ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_seven_seg.sv
// Scoreboard bench for seven_seg with the default active-low polarity.
// Latency: expected values are due one clock edge after the inputs are driven.
// Backpressure: none. The monitor checks each vector on the negedge after it is due.
module tb_seven_seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] num;
    logic [2:0] sel;
    logic [6:0] segment;
    logic [7:0] anode;

    always #5 clk = ~clk;

    seven_seg dut (
        .clk     (clk),
        .rst     (rst),
        .num     (num),
        .sel     (sel),
        .segment (segment),
        .anode   (anode)
    );

    typedef struct {
        logic [6:0] seg;
        logic [7:0] an;
        int         due;
        bit         one_hot;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Active-low glyphs for hex digits 0 through F.
    logic [6:0] seg_map [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Count rising edges. The scoreboard schedules each expected value by this count.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one vector just after a rising edge and queue its expected value.
    // The DUT samples the vector at the next rising edge.
    task automatic drive_exp(input logic r, input logic [3:0] n, input logic [2:0] s,
                             input logic [6:0] eseg, input logic [7:0] ean);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        num = n;
        sel = s;
        e.seg     = eseg;
        e.an      = ean;
        e.due     = cyc + 1;
        e.one_hot = !r;
        sb.push_back(e);
    endtask

    // Build the expected value from the glyph table and the anode rule, then drive.
    task automatic drive(input logic r, input logic [3:0] n, input logic [2:0] s);
        logic [7:0] an_exp;
        an_exp = ~(8'b1 << s);
        if (r) drive_exp(r, n, s, 7'h7F, 8'hFF);
        else   drive_exp(r, n, s, seg_map[n], an_exp);
    endtask

    // Monitor: pop each due vector and compare it with the DUT outputs.
    exp_t got;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && cyc >= sb[0].due) begin
                got = sb.pop_front();
                n_vec++;
                if (segment !== got.seg) begin
                    n_bad++;
                    $display("FAIL segment vec%0d: got %b want %b", n_vec, segment, got.seg);
                end
                if (anode !== got.an) begin
                    n_bad++;
                    $display("FAIL anode vec%0d: got %b want %b", n_vec, anode, got.an);
                end
                if (got.one_hot && $countones(~anode) != 1) begin
                    n_bad++;
                    $display("FAIL anode_onehot vec%0d: got %b want exactly one low bit",
                             n_vec, anode);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        num = 4'h0;
        sel = 3'd0;

        // Reset held for two clocks with arbitrary inputs: display blank.
        drive_exp(1'b1, 4'h3, 3'd5, 7'b1111111, 8'b11111111);
        drive_exp(1'b1, 4'hC, 3'd1, 7'b1111111, 8'b11111111);

        // Directed corners and mid-range values, with hand-written expected outputs.
        drive_exp(1'b0, 4'h0, 3'd0, 7'b1000000, 8'b11111110);
        drive_exp(1'b0, 4'hF, 3'd7, 7'b0001110, 8'b01111111);
        drive_exp(1'b0, 4'hA, 3'd3, 7'b0001000, 8'b11110111);
        drive_exp(1'b0, 4'h5, 3'd4, 7'b0010010, 8'b11101111);

        // Sweep num with the anode fixed on digit 2.
        for (int i = 0; i < 16; i++)
            drive_exp(1'b0, 4'(i), 3'd2, seg_map[i], 8'b11111011);

        // Sweep sel with all segments lit. Reset pulses once partway through the sweep.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h8, 3'(i));
            if (i == 4) drive_exp(1'b1, 4'h8, 3'(i), 7'b1111111, 8'b11111111);
        end

        // Random num/sel pairs checked against the model.
        for (int i = 0; i < 50; i++)
            drive(1'b0, 4'($urandom_range(15)), 3'($urandom_range(7)));

        // Drain the scoreboard, with a bounded wait.
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left, want 0", sb.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
